// File: rtl/i2s_rx_capture_if.sv
// Write-side bus between the I2S capture block and the Avalon bridge.
// Master issues a write and holds it until the bridge acknowledges.
interface i2s_rx_capture_if;
  logic [24:0] ADDR_WR;
  logic [15:0] WRdata;
  logic        WRen;
  logic        avalon_bridge_acknowledge;

  modport master (
    output ADDR_WR,
    output WRdata,
    output WRen,
    input  avalon_bridge_acknowledge
  );

  modport slave (
    input  ADDR_WR,
    input  WRdata,
    input  WRen,
    output avalon_bridge_acknowledge
  );
endinterface

// File: rtl/i2s_rx_capture.sv
// I2S receiver: oversamples codec clocks on clk50, deserialises
// left/right words and streams them to memory through a write bus.
module i2s_rx_capture #(
  parameter int BIT_DEPTH   = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk50,
  input  logic        reset,
  input  logic        I2S_DOUT,
  input  logic        I2S_LRCLK,
  input  logic        I2S_SCLK,
  input  logic        I2S_enable,
  input  logic        ADDR_load,
  input  logic [24:0] ADDR_start,
  input  logic [24:0] ADDR_end,
  i2s_rx_capture_if.master wr,
  output logic        sample_valid,
  output logic        sample_is_right,
  output logic [7:0]  overflow_cnt,
  output logic [3:0]  hex_out_5,
  output logic [3:0]  hex_out_4,
  output logic [3:0]  hex_out_3,
  output logic [3:0]  hex_out_2,
  output logic [3:0]  hex_out_1,
  output logic [3:0]  hex_out_0
);

  localparam int CW = $clog2(BIT_DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE, ALIGN, CAPTURE
  } cap_t;

  typedef enum logic {
    W_IDLE, W_BUSY
  } wst_t;

  logic [SYNC_STAGES-1:0] sclk_sy;
  logic [SYNC_STAGES-1:0] lr_sy;
  logic [SYNC_STAGES-1:0] dout_sy;
  logic sclk_s, lr_s, dout_s;
  logic sclk_d, lr_prev, en_d;
  logic sclk_rise, frame_edge;

  cap_t cap_st, cap_nx;
  wst_t w_st, w_nx;
  logic idle, tracking, capturing;

  logic [CW-1:0]        bit_cnt;
  logic [BIT_DEPTH-1:0] sh;
  logic [BIT_DEPTH-1:0] word;
  logic                 chan;
  logic                 shift_en, word_done;
  logic                 addr_load;
  logic [24:0]          addr;
  logic [15:0]          wdata;
  logic                 ack;

  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      sclk_sy <= '0;
      lr_sy   <= '0;
      dout_sy <= '0;
      sclk_d  <= 1'b0;
      lr_prev <= 1'b0;
      en_d    <= 1'b0;
    end else begin
      sclk_sy <= SYNC_STAGES'({sclk_sy, I2S_SCLK});
      lr_sy   <= SYNC_STAGES'({lr_sy, I2S_LRCLK});
      dout_sy <= SYNC_STAGES'({dout_sy, I2S_DOUT});
      sclk_d  <= sclk_s;
      en_d    <= I2S_enable;
      if (sclk_rise)
        lr_prev <= lr_s;
    end
  end

  assign sclk_s     = sclk_sy[SYNC_STAGES-1];
  assign lr_s       = lr_sy[SYNC_STAGES-1];
  assign dout_s     = dout_sy[SYNC_STAGES-1];
  assign sclk_rise  = sclk_s & ~sclk_d;
  assign frame_edge = sclk_rise & (lr_s ^ lr_prev);

  always_ff @(posedge clk50 or posedge reset) begin
    if (reset)
      cap_st <= IDLE;
    else
      cap_st <= cap_nx;
  end

  always_comb begin
    cap_nx = cap_st;
    if (!I2S_enable)
      cap_nx = IDLE;
    else begin
      unique case (cap_st)
        IDLE:    cap_nx = ALIGN;
        ALIGN:   if (frame_edge && !lr_s)
                   cap_nx = CAPTURE;
        CAPTURE: cap_nx = CAPTURE;
        default: cap_nx = IDLE;
      endcase
    end
  end

  always_comb begin
    idle      = 1'b0;
    tracking  = 1'b0;
    capturing = 1'b0;
    unique case (1'b1)
      (cap_st == ALIGN):   tracking = 1'b1;
      (cap_st == CAPTURE): begin
        tracking  = 1'b1;
        capturing = 1'b1;
      end
      default:             idle = 1'b1;
    endcase
  end

  // The frame-edge sample is the I2S one-bit delay and is discarded.
  assign shift_en  = capturing & I2S_enable & sclk_rise
                   & ~frame_edge
                   & (bit_cnt < CW'(BIT_DEPTH));
  assign word_done = shift_en
                   & (bit_cnt == CW'(BIT_DEPTH - 1));
  assign word      = {sh[BIT_DEPTH-2:0], dout_s};

  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      bit_cnt         <= '0;
      sh              <= '0;
      chan            <= 1'b0;
      sample_valid    <= 1'b0;
      sample_is_right <= 1'b0;
      wdata           <= '0;
      overflow_cnt    <= '0;
    end else begin
      sample_valid <= word_done;
      if (idle)
        bit_cnt <= '0;
      else if (tracking && I2S_enable && frame_edge) begin
        bit_cnt <= '0;
        chan    <= lr_s;
      end else if (shift_en) begin
        sh      <= word;
        bit_cnt <= bit_cnt + 1'b1;
      end
      if (word_done) begin
        sample_is_right <= chan;
        if (w_st == W_IDLE)
          wdata <= 16'(word);
        else if (overflow_cnt != 8'hFF)
          overflow_cnt <= overflow_cnt + 8'd1;
      end
    end
  end

  assign ack       = wr.avalon_bridge_acknowledge;
  assign addr_load = (I2S_enable & ~en_d)
                   | (ADDR_load & idle);

  always_ff @(posedge clk50 or posedge reset) begin
    if (reset)
      addr <= '0;
    else if (addr_load)
      addr <= ADDR_start;
    else if (w_st == W_BUSY && ack)
      addr <= (addr == ADDR_end) ? ADDR_start
                                 : addr + 25'd1;
  end

  always_ff @(posedge clk50 or posedge reset) begin
    if (reset)
      w_st <= W_IDLE;
    else
      w_st <= w_nx;
  end

  always_comb begin
    w_nx = w_st;
    unique case (w_st)
      W_IDLE:  if (word_done) w_nx = W_BUSY;
      W_BUSY:  if (ack)       w_nx = W_IDLE;
      default: w_nx = W_IDLE;
    endcase
  end

  always_comb begin
    wr.WRen    = (w_st == W_BUSY);
    wr.WRdata  = wdata;
    wr.ADDR_WR = addr;
  end

  assign hex_out_5 = addr[23:20];
  assign hex_out_4 = addr[19:16];
  assign hex_out_3 = addr[15:12];
  assign hex_out_2 = addr[11:8];
  assign hex_out_1 = addr[7:4];
  assign hex_out_0 = addr[3:0];

endmodule

// File: doc/i2s_rx_capture.md
I2S_RX_CAPTURE -- requirements
Module: i2s_rx_capture

Interface
REQ-001: The parameters SHALL be as follows, one per line.
- BIT_DEPTH, 16, bits captured per channel slot, MSB first.
- SYNC_STAGES, 2, flip-flop stages on each codec input.
REQ-002: The ports SHALL be as follows, one per line.
- clk50  input  1  system clock, 50 MHz.
- reset  input  1  asynchronous, active-high reset.
- I2S_DOUT  input  1  serial data from the codec ADC.
- I2S_LRCLK  input  1  frame clock from the codec master; low = left, high = right; 44.1 kHz.
- I2S_SCLK  input  1  bit clock from the codec master, 64x LRCLK.
- I2S_enable  input  1  capture enable.
- ADDR_load  input  1  one-cycle pulse that reloads the write address.
- ADDR_start  input  25  first write address; one address per 16-bit word.
- ADDR_end  input  25  last write address, inclusive.
- ADDR_WR  output  25  memory write address.
- WRdata  output  16  memory write data.
- WRen  output  1  write request.
- avalon_bridge_acknowledge  input  1  write accepted.
- sample_valid  output  1  one-cycle pulse when a word is completed.
- sample_is_right  output  1  channel tag of the last completed word.
- overflow_cnt  output  8  count of dropped words, saturating.
- hex_out_5..hex_out_0  output  4 each  nibbles 23:20 down to 3:0 of the current write address.

Function
REQ-003: SCLK, LRCLK and DOUT SHALL each pass through SYNC_STAGES flip-flops on clk50; all logic SHALL run on clk50 only.
REQ-004: An SCLK rising edge SHALL be detected as synchronized SCLK 0 in the previous cycle and 1 in the current cycle; it is called sclk_rise below.
REQ-005: On every sclk_rise, synchronized LRCLK SHALL be stored in lr_prev.
- A "frame edge" is an sclk_rise at which synchronized LRCLK differs from lr_prev.
REQ-006: The capture FSM SHALL have three states: IDLE, ALIGN and CAPTURE.
- IDLE to ALIGN on I2S_enable=1.
- ALIGN to CAPTURE on a frame edge where LRCLK goes 1 to 0 (left slot start).
- Any state to IDLE when I2S_enable=0.
REQ-007: On a frame edge in ALIGN or CAPTURE, bit_cnt SHALL clear to 0 and the channel tag SHALL take the new LRCLK value.
- The bit sampled at that edge SHALL be discarded; this is the I2S one-bit delay.
REQ-008: In CAPTURE, each later sclk_rise with bit_cnt < BIT_DEPTH SHALL shift synchronized DOUT into the shift register, LSB side, and increment bit_cnt.
- Slot bits after BIT_DEPTH SHALL be ignored.
REQ-009: When bit_cnt reaches BIT_DEPTH, the word SHALL be complete.
- sample_valid SHALL pulse high for exactly one clk50 cycle, in the cycle after the 16th shift.
- sample_is_right SHALL update to the word's channel tag in that same cycle.
REQ-010: Write side SHALL be a two-state FSM, W_IDLE and W_BUSY.
- A completed word in W_IDLE SHALL load WRdata and set WRen=1 in the same cycle as sample_valid, entering W_BUSY.
REQ-011: In W_BUSY, WRen, WRdata and ADDR_WR SHALL hold stable until a cycle with avalon_bridge_acknowledge=1.
- In the cycle after the acknowledge, WRen SHALL be 0 and the FSM SHALL be in W_IDLE.
- The address SHALL increment by 1, or load ADDR_start if it equalled ADDR_end (wrap).
REQ-012: A word completed while in W_BUSY SHALL be dropped.
- overflow_cnt SHALL increment, saturating at 8'hFF.
- sample_valid SHALL still pulse.
REQ-013: The address SHALL load ADDR_start on an I2S_enable 0-to-1 transition, or on ADDR_load=1 while the capture FSM is in IDLE.
- ADDR_load outside IDLE SHALL be ignored.
REQ-014: Deasserting I2S_enable SHALL abort a partial word with no write.
- A write already in W_BUSY SHALL complete normally on acknowledge.
REQ-015: A frame edge arriving before bit_cnt reaches BIT_DEPTH SHALL restart the slot per REQ-007 with no write; this covers short or glitched frames.
REQ-016: Unused acknowledges, meaning acknowledge=1 in W_IDLE, SHALL be ignored.

Reset
REQ-017: While reset=1, asynchronously:
- Both FSMs SHALL be in IDLE / W_IDLE.
- WRen=0, WRdata=16'h0000, sample_valid=0, sample_is_right=0.
- ADDR_WR=25'h0000000, overflow_cnt=8'h00.
- bit_cnt=0, lr_prev=0, and all synchronizer flops=0.
REQ-018: Reset asserted mid-write SHALL drop WRen immediately; no write SHALL be issued after release until a new word completes.

Verification
REQ-019: Basic capture
- Stimulus: ADDR_start=0x100, enable, then left word 0xA5C3 and right word 0x1234; acknowledge 3 cycles after each WRen.
- Required: writes (0x100, 0xA5C3) then (0x101, 0x1234); sample_is_right is 0 then 1.
REQ-020: Enable mid-right-slot
- Stimulus: enable asserted partway through a right slot.
- Required: no write for that partial slot; the first write is the next left word, at ADDR_start.
REQ-021: Address wrap
- Stimulus: ADDR_start=0x10, ADDR_end=0x11, three words 0x0001, 0x0002, 0x0003.
- Required: writes to addresses 0x10, 0x11, 0x10.
REQ-022: Overflow
- Stimulus: hold acknowledge=0 across three completed words.
- Required: only the first word is written, and only once acknowledge arrives; overflow_cnt=2; sample_valid pulses three times.
REQ-023: Short frame
- Stimulus: LRCLK toggles after 8 data bits.
- Required: no write for that slot; the next full 16-bit word is captured correctly.
REQ-024: Mid-write reset
- Stimulus: reset pulse while WRen=1.
- Required: WRen=0 and ADDR_WR=0 during reset; no spurious write after release.
